// File: rtl/z80db_pkg.sv
// Shared definitions for the Z80 debug-board CPLD blocks.
// Holds the cache loader state encoding, its default timing constants and
// a helper that sizes a down-counter able to hold the larger of two loads.
package z80db_pkg;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_REQ,
    ST_GRANT,
    ST_WAIT_IN,
    ST_STROBE,
    ST_HOLD,
    ST_PUSH,
    ST_NEXT,
    ST_RELEASE,
    ST_UNREQ,
    ST_DONE,
    ST_ABORT
  } state_t;

  localparam int DEF_PULSE_CYC = 2;
  localparam int DEF_ACK_TMO   = 1024;

  function automatic int cnt_width(input int a, input int b);
    int m;
    m = (a > b) ? a : b;
    return $clog2(m + 1);
  endfunction

endpackage

// File: rtl/cache_loader_sync2.sv
// Two-flop synchroniser for a single asynchronous level.
// Ports: clk, reset (async active-low), d (async input), q (synchronised).
// Both flops clear to 1 so an inactive-high strobe reads as idle out of reset.
module sync2 (
  input  logic clk,
  input  logic reset,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      meta <= 1'b1;
      q    <= 1'b1;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/cache_loader.sv
// Host-side DMA sequencer for the 32 KB cache SRAM (two 16 KB banks).
// Requests the Z80 bus, then loads a bank from the host byte stream or reads
// it back to the host, driving SRAM strobes with a fixed pulse width, and
// finally hands the bus back to the CPU.
// Ports: clk/reset; cmd_* command; in_* load stream; out_* readback stream;
// busrq_n/busack_n Z80 bus handshake; sram_* SRAM pins; own_bus strobe-mux
// select; busy/done/err_tmo status.
//
// state      | meaning
// IDLE       | waiting for cmd_start
// REQ        | busrq_n low, waiting for synced busack (timeout -> ABORT)
// GRANT      | bus owned, address/bank settle before the first strobe
// WAIT_IN    | load: waiting for a host byte
// STROBE     | we_n or oe_n low for PULSE_CYC cycles
// HOLD       | load: we_n high, data/address held one cycle
// PUSH       | readback: byte offered to the host
// NEXT       | step to next byte or finish
// RELEASE    | strobes/bus mux released, busrq_n still low
// UNREQ      | busrq_n high, waiting for busack to deassert
// DONE       | completion pulse
// ABORT      | busack timeout: completion + error pulse
module cache_loader
  import z80db_pkg::*;
#(
  parameter int ADDR_W    = 14,
  parameter int PULSE_CYC = DEF_PULSE_CYC,
  parameter int ACK_TMO   = DEF_ACK_TMO
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cmd_start,
  input  logic              cmd_write,
  input  logic              cmd_bank,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic [ADDR_W:0]   cmd_len,
  input  logic [7:0]        in_data,
  input  logic              in_valid,
  output logic              in_ready,
  output logic [7:0]        out_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              busrq_n,
  input  logic              busack_n,
  output logic [ADDR_W-1:0] sram_a,
  output logic              sram_a14,
  output logic [7:0]        sram_d_o,
  output logic              sram_d_oe,
  input  logic [7:0]        sram_d_i,
  output logic              sram_ce_n,
  output logic              sram_oe_n,
  output logic              sram_we_n,
  output logic              own_bus,
  output logic              busy,
  output logic              done,
  output logic              err_tmo
);

  localparam int CNT_W = cnt_width(PULSE_CYC, ACK_TMO);

  state_t            state, state_nx;
  logic              is_wr;
  logic              bank;
  logic [ADDR_W-1:0] addr;
  logic [ADDR_W:0]   rem;
  logic [7:0]        data;
  logic [CNT_W-1:0]  cnt;
  logic              busack_s;

  sync2 u_sync_ack (
    .clk   (clk),
    .reset (reset),
    .d     (busack_n),
    .q     (busack_s)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= ST_IDLE;
    else        state <= state_nx;
  end

  // Shared counter: busack timeout in REQ, strobe width in STROBE.
  // Address/remaining step on leaving HOLD/PUSH so NEXT already shows the
  // new address with strobes inactive.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      is_wr <= 1'b0;
      bank  <= 1'b0;
      addr  <= '0;
      rem   <= '0;
      data  <= '0;
      cnt   <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (cmd_start && cmd_len != '0) begin
            is_wr <= cmd_write;
            bank  <= cmd_bank;
            addr  <= cmd_addr;
            rem   <= cmd_len;
            cnt   <= CNT_W'(ACK_TMO - 1);
          end
        end
        ST_REQ: if (cnt != '0) cnt <= cnt - 1'b1;
        ST_GRANT, ST_NEXT: cnt <= CNT_W'(PULSE_CYC - 1);
        ST_WAIT_IN: if (in_valid) data <= in_data;
        ST_STROBE: begin
          if (cnt != '0) cnt <= cnt - 1'b1;
          else if (!is_wr) data <= sram_d_i;
        end
        ST_HOLD: begin
          addr <= addr + 1'b1;
          rem  <= rem - 1'b1;
        end
        ST_PUSH: begin
          if (out_ready) begin
            addr <= addr + 1'b1;
            rem  <= rem - 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    state_nx  = state;
    busrq_n   = 1'b1;
    own_bus   = 1'b0;
    sram_ce_n = 1'b1;
    sram_we_n = 1'b1;
    sram_oe_n = 1'b1;
    sram_d_oe = 1'b0;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    busy      = 1'b1;
    done      = 1'b0;
    err_tmo   = 1'b0;
    case (state)
      ST_IDLE: begin
        busy = 1'b0;
        if (cmd_start) state_nx = (cmd_len == '0) ? ST_DONE : ST_REQ;
      end
      ST_REQ: begin
        busrq_n = 1'b0;
        if (!busack_s)       state_nx = ST_GRANT;
        else if (cnt == '0)  state_nx = ST_ABORT;
      end
      ST_GRANT: begin
        busrq_n   = 1'b0;
        own_bus   = 1'b1;
        sram_ce_n = 1'b0;
        state_nx  = is_wr ? ST_WAIT_IN : ST_STROBE;
      end
      ST_WAIT_IN: begin
        busrq_n   = 1'b0;
        own_bus   = 1'b1;
        sram_ce_n = 1'b0;
        in_ready  = 1'b1;
        if (in_valid) state_nx = ST_STROBE;
      end
      ST_STROBE: begin
        busrq_n   = 1'b0;
        own_bus   = 1'b1;
        sram_ce_n = 1'b0;
        sram_we_n = !is_wr;
        sram_oe_n = is_wr;
        sram_d_oe = is_wr;
        if (cnt == '0) state_nx = is_wr ? ST_HOLD : ST_PUSH;
      end
      ST_HOLD: begin
        busrq_n   = 1'b0;
        own_bus   = 1'b1;
        sram_ce_n = 1'b0;
        sram_d_oe = 1'b1;
        state_nx  = ST_NEXT;
      end
      ST_PUSH: begin
        busrq_n   = 1'b0;
        own_bus   = 1'b1;
        sram_ce_n = 1'b0;
        out_valid = 1'b1;
        if (out_ready) state_nx = ST_NEXT;
      end
      ST_NEXT: begin
        busrq_n   = 1'b0;
        own_bus   = 1'b1;
        sram_ce_n = 1'b0;
        if (rem == '0) state_nx = ST_RELEASE;
        else           state_nx = is_wr ? ST_WAIT_IN : ST_STROBE;
      end
      ST_RELEASE: begin
        busrq_n  = 1'b0;
        state_nx = ST_UNREQ;
      end
      ST_UNREQ: begin
        if (busack_s) state_nx = ST_DONE;
      end
      ST_DONE: begin
        busy     = 1'b0;
        done     = 1'b1;
        state_nx = ST_IDLE;
      end
      ST_ABORT: begin
        busy     = 1'b0;
        done     = 1'b1;
        err_tmo  = 1'b1;
        state_nx = ST_IDLE;
      end
      default: begin
        busy     = 1'b0;
        state_nx = ST_IDLE;
      end
    endcase
  end

  assign out_data = data;
  assign sram_d_o = data;
  assign sram_a   = addr;
  assign sram_a14 = bank;

endmodule

// File: tb/tb_cache_loader.sv
// Self-checking bench for cache_loader: SRAM and Z80 BUSACK models, host
// stream drivers, a per-cycle compare process against expected strobe
// addresses/data and readback bytes, plus literal checks of known cases.
module tb_cache_loader;

  localparam int ADDR_W  = 14;
  localparam int PULSE   = 2;
  localparam int TMO     = 1024;
  localparam int MEM_SZ  = 32768;

  logic              clk = 1'b0;
  logic              reset;
  logic              cmd_start, cmd_write, cmd_bank;
  logic [ADDR_W-1:0] cmd_addr;
  logic [ADDR_W:0]   cmd_len;
  logic [7:0]        in_data;
  logic              in_valid, in_ready;
  logic [7:0]        out_data;
  logic              out_valid, out_ready;
  logic              busrq_n, busack_n;
  logic [ADDR_W-1:0] sram_a;
  logic              sram_a14;
  logic [7:0]        sram_d_o, sram_d_i;
  logic              sram_d_oe, sram_ce_n, sram_oe_n, sram_we_n;
  logic              own_bus, busy, done, err_tmo;

  cache_loader #(.ADDR_W(ADDR_W), .PULSE_CYC(PULSE), .ACK_TMO(TMO)) dut (
    .clk(clk), .reset(reset),
    .cmd_start(cmd_start), .cmd_write(cmd_write), .cmd_bank(cmd_bank),
    .cmd_addr(cmd_addr), .cmd_len(cmd_len),
    .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
    .busrq_n(busrq_n), .busack_n(busack_n),
    .sram_a(sram_a), .sram_a14(sram_a14), .sram_d_o(sram_d_o),
    .sram_d_oe(sram_d_oe), .sram_d_i(sram_d_i),
    .sram_ce_n(sram_ce_n), .sram_oe_n(sram_oe_n), .sram_we_n(sram_we_n),
    .own_bus(own_bus), .busy(busy), .done(done), .err_tmo(err_tmo)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h t=%0t", nm, act, exp, $time);
    end
  endtask

  // SRAM contents as written by the DUT, and the contents the spec implies.
  logic [7:0]  mem       [MEM_SZ];
  logic [7:0]  model_mem [MEM_SZ];
  assign sram_d_i = sram_oe_n ? 8'h00 : mem[{sram_a14, sram_a}];

  logic [14:0] exp_addr[$];
  logic [7:0]  exp_wdata[$];
  logic [7:0]  exp_rd[$];
  logic [7:0]  tx_q[$];
  logic [7:0]  pat_q[$];
  logic [14:0] addr_log[$];
  logic [7:0]  rx_log[$];

  int  n_done, n_rq, n_strobes, stall_seen;
  int  ack_delay = 3;
  bit  ack_hang  = 0;
  bit  gaps      = 0;
  int  rd_count, stall_idx, stall_left;

  // Z80 model: BUSACK follows BUSRQ after ack_delay cycles, releases at once.
  initial begin
    int lowcnt = 0;
    busack_n = 1'b1;
    forever begin
      @(posedge clk); #1;
      if (busrq_n === 1'b0) begin
        lowcnt++;
        if (!ack_hang && lowcnt >= ack_delay) busack_n = 1'b0;
      end else begin
        lowcnt   = 0;
        busack_n = 1'b1;
      end
    end
  end

  // Host drivers for the load and readback streams.
  initial begin
    bit acc_in, acc_out;
    in_valid  = 1'b0;
    in_data   = 8'h00;
    out_ready = 1'b1;
    forever begin
      @(negedge clk);
      acc_in  = in_valid && in_ready;
      acc_out = out_valid && out_ready;
      @(posedge clk); #1;
      if (acc_in && tx_q.size() > 0) void'(tx_q.pop_front());
      if (acc_out) rd_count++;
      if (tx_q.size() > 0 && (!gaps || $urandom_range(3) != 0)) begin
        in_valid = 1'b1;
        in_data  = tx_q[0];
      end else begin
        in_valid = 1'b0;
        in_data  = 8'($urandom);
      end
      if (stall_left > 0 && rd_count == stall_idx) begin
        out_ready = 1'b0;
        if (out_valid) stall_left--;
      end else begin
        out_ready = gaps ? 1'($urandom_range(1)) : 1'b1;
      end
    end
  end

  // Per-cycle compare against the expectation queues and bus rules.
  initial begin
    bit          prev_strobe = 0;
    bit          pv_valid = 0, pv_acc = 0;
    bit          strobe;
    int          plen = 0;
    logic [14:0] cur_addr = '0;
    logic [7:0]  held = '0;
    forever begin
      @(negedge clk);
      if (!reset) begin
        prev_strobe = 0;
        pv_valid    = 0;
        pv_acc      = 0;
      end else begin
        strobe = !sram_we_n || !sram_oe_n;
        chk("we_oe_exclusive", {sram_we_n, sram_oe_n} == 2'b00, 0);
        chk("doe_during_read", sram_d_oe && !sram_oe_n, 0);
        chk("own_needs_busrq", own_bus && busrq_n, 0);
        chk("err_implies_done", err_tmo && !done, 0);
        if (done) n_done++;
        if (!busrq_n) n_rq++;
        if (strobe && !prev_strobe) begin
          n_strobes++;
          plen     = 1;
          cur_addr = {sram_a14, sram_a};
          addr_log.push_back(cur_addr);
          chk("strobe_expected", exp_addr.size() > 0, 1);
          chk("strobe_addr", cur_addr, (exp_addr.size() > 0) ? exp_addr.pop_front() : 15'h7fff);
          chk("strobe_own_ce", {own_bus, sram_ce_n}, 2'b10);
          if (!sram_we_n) begin
            chk("wr_doe", sram_d_oe, 1);
            chk("wr_data", sram_d_o, (exp_wdata.size() > 0) ? exp_wdata.pop_front() : 8'hxx);
          end
        end else if (strobe) begin
          plen++;
          chk("strobe_addr_hold", {sram_a14, sram_a}, cur_addr);
        end
        if (!strobe && prev_strobe) chk("pulse_len", plen, PULSE);
        if (!sram_we_n) mem[{sram_a14, sram_a}] = sram_d_o;
        prev_strobe = strobe;

        if (out_valid) begin
          if (pv_valid && !pv_acc) chk("out_stable", out_data, held);
          held = out_data;
          if (!out_ready) stall_seen++;
          else begin
            rx_log.push_back(out_data);
            chk("rd_expected", exp_rd.size() > 0, 1);
            chk("rd_data", out_data, (exp_rd.size() > 0) ? exp_rd.pop_front() : 8'hxx);
          end
        end
        pv_valid = out_valid;
        pv_acc   = out_valid && out_ready;
      end
    end
  end

  task automatic run_cmd(input bit wr, input bit bk, input int a, input int len,
                         input int dly, input bit hang, input bit poke);
    int          k, budget;
    logic [14:0] ea;
    logic [7:0]  b;
    n_done = 0; n_rq = 0; n_strobes = 0; stall_seen = 0; rd_count = 0;
    addr_log.delete(); rx_log.delete();
    ack_delay = dly;
    ack_hang  = hang;
    if (!hang) begin
      for (int i = 0; i < len; i++) begin
        ea = {bk, 14'((a + i) % 16384)};
        exp_addr.push_back(ea);
        if (wr) begin
          b = (pat_q.size() > 0) ? pat_q.pop_front() : 8'($urandom);
          tx_q.push_back(b);
          exp_wdata.push_back(b);
          model_mem[ea] = b;
        end else begin
          exp_rd.push_back(model_mem[ea]);
        end
      end
    end
    @(posedge clk); #1;
    cmd_start = 1'b1; cmd_write = wr; cmd_bank = bk;
    cmd_addr = 14'(a); cmd_len = 15'(len);
    @(posedge clk); #1;
    cmd_start = 1'b0;
    cmd_write = 1'($urandom); cmd_bank = 1'($urandom);
    cmd_addr = 14'($urandom); cmd_len = 15'($urandom_range(1, 9));
    budget = 2000 + len * 60;
    k = 0;
    while (!done && k < budget) begin
      if (poke) cmd_start = (k == 10);
      @(posedge clk); #1;
      k++;
    end
    cmd_start = 1'b0;
    chk("done_seen", done, 1);
    chk("err_tmo", err_tmo, hang);
    chk("busy_at_done", busy, 0);
    chk("busrq_at_done", busrq_n, 1);
    if (len == 0) chk("len0_latency", k, 0);
    repeat (20) begin @(posedge clk); #1; end
    chk("done_count", n_done, 1);
    chk("exp_addr_left", exp_addr.size(), 0);
    chk("exp_wdata_left", exp_wdata.size(), 0);
    chk("exp_rd_left", exp_rd.size(), 0);
    chk("tx_left", tx_q.size(), 0);
    chk("idle_busrq", busrq_n, 1);
    if (hang) begin
      chk("tmo_busrq_cycles", n_rq, TMO);
      chk("tmo_strobes", n_strobes, 0);
    end else begin
      chk("strobe_count", n_strobes, len);
      if (len == 0) chk("len0_busrq_cycles", n_rq, 0);
    end
  endtask

  initial begin
    int    prev_a, prev_len, k, mm;
    bit    prev_bk, wr, bk;
    bit    found;
    logic [7:0] b;
    logic [7:0] lit_pat [4];
    lit_pat[0] = 8'hAA; lit_pat[1] = 8'h55; lit_pat[2] = 8'h01; lit_pat[3] = 8'hFF;

    for (int i = 0; i < MEM_SZ; i++) begin
      b = 8'($urandom);
      mem[i] = b;
      model_mem[i] = b;
    end
    reset = 1'b0;
    cmd_start = 0; cmd_write = 0; cmd_bank = 0; cmd_addr = '0; cmd_len = '0;
    stall_idx = 0; stall_left = 0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_busrq", busrq_n, 1);
    chk("rst_strobes", {sram_ce_n, sram_oe_n, sram_we_n}, 3'b111);
    chk("rst_doe_own", {sram_d_oe, own_bus}, 2'b00);
    chk("rst_handshake", {in_ready, out_valid}, 2'b00);
    chk("rst_status", {busy, done, err_tmo}, 3'b000);
    reset = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("idle_busy", busy, 0);

    // Directed load AA 55 01 FF to bank 1 at 0, BUSACK after 5 cycles.
    for (int i = 0; i < 4; i++) pat_q.push_back(lit_pat[i]);
    run_cmd(1, 1, 0, 4, 5, 0, 0);
    for (int i = 0; i < 4; i++) begin
      chk("load_lit_addr", addr_log[i], 15'h4000 + 15'(i));
      chk("load_lit_mem", mem[15'h4000 + i], lit_pat[i]);
    end

    // Readback with byte 2 stalled 3 cycles.
    stall_idx = 1; stall_left = 3;
    run_cmd(0, 1, 0, 4, 4, 0, 0);
    chk("rb_stall_cycles", stall_seen >= 3, 1);
    chk("rb_count", rx_log.size(), 4);
    for (int i = 0; i < 4; i++) chk("rb_lit_data", rx_log[i], lit_pat[i]);
    stall_left = 0;

    // Wrap inside the bank.
    run_cmd(1, 0, 14'h3FFE, 4, 2, 0, 0);
    chk("wrap_a0", addr_log[0], 15'h3FFE);
    chk("wrap_a1", addr_log[1], 15'h3FFF);
    chk("wrap_a2", addr_log[2], 15'h0000);
    chk("wrap_a3", addr_log[3], 15'h0001);

    // BUSACK never arrives.
    run_cmd(1, 0, 14'h0100, 3, 1, 1, 0);

    // Zero length.
    run_cmd(1, 1, 14'h0200, 0, 3, 0, 0);

    // cmd_start while busy must be ignored.
    run_cmd(1, 1, 14'h0300, 3, 3, 0, 1);

    // Reset in the middle of a write strobe.
    ack_delay = 3; ack_hang = 0;
    for (int i = 0; i < 4; i++) begin
      exp_addr.push_back({1'b0, 14'h0400 + 14'(i)});
      b = 8'($urandom);
      tx_q.push_back(b);
      exp_wdata.push_back(b);
    end
    @(posedge clk); #1;
    cmd_start = 1; cmd_write = 1; cmd_bank = 0; cmd_addr = 14'h0400; cmd_len = 15'd4;
    @(posedge clk); #1;
    cmd_start = 0;
    found = 0;
    k = 0;
    while (!found && k < 200) begin
      if (sram_we_n === 1'b0) found = 1;
      else begin @(posedge clk); #1; k++; end
    end
    chk("rst_mid_found_strobe", found, 1);
    reset = 1'b0;
    #1;
    chk("rst_mid_busrq", busrq_n, 1);
    chk("rst_mid_we", sram_we_n, 1);
    chk("rst_mid_doe", sram_d_oe, 0);
    chk("rst_mid_busy", busy, 0);
    chk("rst_mid_own", own_bus, 0);
    tx_q.delete(); exp_addr.delete(); exp_wdata.delete();
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b1;
    repeat (4) @(posedge clk);
    run_cmd(1, 0, 14'h0500, 3, 4, 0, 0);

    // Randomized traffic; odd commands read back the previous region.
    gaps = 1;
    prev_a = 0; prev_bk = 0; prev_len = 0;
    for (int n = 0; n < 14; n++) begin
      if (n % 2 == 1) begin
        run_cmd(0, prev_bk, prev_a, prev_len, $urandom_range(1, 8), 0, 0);
      end else begin
        wr = 1'($urandom_range(1));
        bk = 1'($urandom_range(1));
        prev_a = ($urandom_range(3) == 0) ? 16384 - $urandom_range(1, 4) : $urandom_range(16383);
        prev_len = $urandom_range(0, 6);
        prev_bk = bk;
        run_cmd(wr, bk, prev_a, prev_len, $urandom_range(1, 8), 0, 0);
      end
    end

    mm = 0;
    for (int i = 0; i < MEM_SZ; i++) if (mem[i] !== model_mem[i]) mm++;
    chk("sram_contents", mm, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
